// File: rtl/invkeyschedule.sv
// Inverse AES-128 key schedule: expands the cipher key forward to round 10,
// then serves round keys 10..0 in descending order, one step per request.
module invkeyschedule (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0][3:0][7:0]  cipherkey,
   input  logic                  next,
   output logic [3:0][3:0][7:0]  roundkey,
   output logic [3:0]            round,
   output logic                  valid,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned NUM_ROUNDS = 10;
   localparam int unsigned NUM_ROWS   = 4;

   typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] rcon_of(input logic [3:0] idx);
      logic [7:0] rc;
      rc = 8'h00;
      case (idx)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   state_t               state;
   logic [3:0][7:0]      sel_col;
   logic [3:0][7:0]      sub_col;
   logic [3:0][7:0]      rcon_col;
   logic [3:0]           rcon_idx;
   logic [3:0][3:0][7:0] fwd_key;
   logic [3:0][3:0][7:0] bwd_key;

   // One S-box column shared: forward uses w3, backward uses the recovered p3 = w3 ^ w2.
   always_comb begin
      sel_col  = '0;
      sub_col  = '0;
      fwd_key  = '0;
      bwd_key  = '0;
      rcon_idx = (state == SERVE) ? round : 4'(round + 4'd1);
      rcon_col = {8'h00, 8'h00, 8'h00, rcon_of(rcon_idx)};
      for (int r = 0; r < NUM_ROWS; r++) begin
         sel_col[r] = (state == SERVE) ? (roundkey[r][3] ^ roundkey[r][2]) : roundkey[r][3];
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
         sub_col[r] = SBOX[sel_col[2'(r + 1)]];
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
         fwd_key[r][0] = roundkey[r][0] ^ sub_col[r] ^ rcon_col[r];
         fwd_key[r][1] = roundkey[r][1] ^ fwd_key[r][0];
         fwd_key[r][2] = roundkey[r][2] ^ fwd_key[r][1];
         fwd_key[r][3] = roundkey[r][3] ^ fwd_key[r][2];
         bwd_key[r][3] = roundkey[r][3] ^ roundkey[r][2];
         bwd_key[r][2] = roundkey[r][2] ^ roundkey[r][1];
         bwd_key[r][1] = roundkey[r][1] ^ roundkey[r][0];
         bwd_key[r][0] = roundkey[r][0] ^ sub_col[r] ^ rcon_col[r];
      end
   end

   // Control and key register; start overrides next, reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         roundkey <= '0;
         round    <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
      end else if (start) begin
         state    <= EXPAND;
         roundkey <= cipherkey;
         round    <= '0;
         valid    <= 1'b0;
         busy     <= 1'b1;
      end else begin
         case (state)
            IDLE: ;
            EXPAND: begin
               roundkey <= fwd_key;
               round    <= 4'(round + 4'd1);
               if (round == 4'(NUM_ROUNDS - 1)) begin
                  state <= SERVE;
                  busy  <= 1'b0;
                  valid <= 1'b1;
               end
            end
            SERVE: begin
               if (next && (round != 4'd0)) begin
                  roundkey <= bwd_key;
                  round    <= 4'(round - 4'd1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done = valid && (round == 4'd0);

endmodule

// File: tb/tb_invkeyschedule.sv
// Directed and model-based bench for the inverse AES-128 key schedule.
module tb_invkeyschedule;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [3:0][3:0][7:0] cipherkey;
   logic                 next;
   logic [3:0][3:0][7:0] roundkey;
   logic [3:0]           round;
   logic                 valid;
   logic                 busy;
   logic                 done;

   int checks = 0;
   int errors = 0;

   invkeyschedule dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cipherkey (cipherkey),
      .next      (next),
      .roundkey  (roundkey),
      .round     (round),
      .valid     (valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        nxt;
      logic [3:0]  rnd;
      logic [127:0] key;
      logic        dn;
   } vec_t;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic [127:0] fips_rk [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   logic [7:0]   rcon_tb [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [7:0]   sbox_tb [256];
   logic [127:0] exp_rk [11];
   vec_t         walk [12];

   function automatic logic [3:0][3:0][7:0] to_arr(input logic [127:0] h);
      logic [3:0][3:0][7:0] a;
      for (int k = 0; k < 16; k++) a[k % 4][k / 4] = h[127 - 8 * k -: 8];
      return a;
   endfunction

   function automatic logic [127:0] from_arr(input logic [3:0][3:0][7:0] a);
      logic [127:0] h;
      for (int k = 0; k < 16; k++) h[127 - 8 * k -: 8] = a[k % 4][k / 4];
      return h;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box derived from GF(2^8) inversion plus the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
            t = t ^ {rcon_tb[i / 4], 24'h000000};
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " key"},   from_arr(roundkey), 128'h0);
      chk({tag, " round"}, 128'(round), 128'h0);
      chk({tag, " valid"}, 128'(valid), 128'h0);
      chk({tag, " busy"},  128'(busy),  128'h0);
      chk({tag, " done"},  128'(done),  128'h0);
   endtask

   // Called at a falling edge; returns at the falling edge after the round-10 key lands.
   task automatic start_seq(input logic [127:0] key, input logic nxt_during, input string tag);
      start     = 1'b1;
      cipherkey = to_arr(key);
      next      = nxt_during;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " load key"},   from_arr(roundkey), key);
      chk({tag, " load round"}, 128'(round), 128'h0);
      for (int i = 0; i < 10; i++) begin
         chk({tag, " busy"},  128'(busy),  128'h1);
         chk({tag, " valid"}, 128'(valid), 128'h0);
         @(negedge clk);
      end
      next = 1'b0;
      chk({tag, " busy end"},  128'(busy),  128'h0);
      chk({tag, " valid end"}, 128'(valid), 128'h1);
      chk({tag, " round 10"},  128'(round), 128'd10);
      chk({tag, " done r10"},  128'(done),  128'h0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      next      = 1'b0;
      cipherkey = '0;
      build_sbox();

      for (int i = 0; i < 12; i++) begin
         int r;
         r = (i < 10) ? (9 - i) : 0;
         walk[i].nxt = 1'b1;
         walk[i].rnd = 4'(r);
         walk[i].key = fips_rk[r];
         walk[i].dn  = (r == 0);
      end

      repeat (2) @(negedge clk);
      chk_reset("reset");
      reset = 1'b0;
      @(negedge clk);

      // FIPS-197 key: expansion then descending walk with next held high.
      start_seq(FIPS_KEY, 1'b0, "fips");
      chk("fips r10 key", from_arr(roundkey), fips_rk[10]);
      for (int i = 0; i < 12; i++) begin
         next = walk[i].nxt;
         @(negedge clk);
         chk($sformatf("walk%0d round", i), 128'(round), 128'(walk[i].rnd));
         chk($sformatf("walk%0d key", i),   from_arr(roundkey), walk[i].key);
         chk($sformatf("walk%0d valid", i), 128'(valid), 128'h1);
         chk($sformatf("walk%0d done", i),  128'(done),  128'(walk[i].dn));
      end
      next = 1'b0;

      // next held through expansion is ignored.
      start_seq(FIPS_KEY, 1'b1, "nxt_exp");
      chk("nxt_exp r10 key", from_arr(roundkey), fips_rk[10]);

      // Step to round 5, then start (zero key) together with next.
      for (int i = 0; i < 5; i++) begin
         next = 1'b1;
         @(negedge clk);
      end
      chk("r5 round", 128'(round), 128'd5);
      chk("r5 key", from_arr(roundkey), fips_rk[5]);
      start_seq(128'h0, 1'b1, "zero");
      chk("zero r10 key", from_arr(roundkey), ZERO_R10);

      // Reset during expansion.
      start     = 1'b1;
      cipherkey = to_arr(FIPS_KEY);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid exp busy", 128'(busy), 128'h1);
      reset = 1'b1;
      @(negedge clk);
      chk_reset("rst exp");
      reset = 1'b0;
      @(negedge clk);
      chk_reset("idle hold");

      // Reset at serve round 3, asserted together with start.
      start_seq(FIPS_KEY, 1'b0, "pre_rst");
      for (int i = 0; i < 7; i++) begin
         next = 1'b1;
         @(negedge clk);
      end
      next = 1'b0;
      chk("r3 round", 128'(round), 128'd3);
      chk("r3 key", from_arr(roundkey), fips_rk[3]);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      chk_reset("rst serve");
      reset = 1'b0;
      start = 1'b0;
      start_seq(FIPS_KEY, 1'b0, "post_rst");
      chk("post_rst r10 key", from_arr(roundkey), fips_rk[10]);

      // Random keys against the software expansion.
      for (int n = 0; n < 4; n++) begin
         logic [127:0] key;
         key = {$urandom, $urandom, $urandom, $urandom};
         model_expand(key);
         start_seq(key, 1'b0, "rnd");
         chk($sformatf("rnd%0d r10", n), from_arr(roundkey), exp_rk[10]);
         for (int r = 9; r >= 0; r--) begin
            next = 1'b1;
            @(negedge clk);
            chk($sformatf("rnd%0d round", n), 128'(round), 128'(r));
            chk($sformatf("rnd%0d key r%0d", n, r), from_arr(roundkey), exp_rk[r]);
         end
         next = 1'b0;
         chk($sformatf("rnd%0d done", n), 128'(done), 128'h1);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
